// File: rtl/ahb_rr_arbiter.sv
// AHB bus arbiter: round-robin or fixed-priority grant with burst-aware handover,
// locked transfers and SPLIT masking. Master 0 is the dummy master.
module ahb_rr_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 1,
  parameter int RR_MODE        = 1,
  parameter int INCR_MAX       = 16
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic [1:0]             HRESP,
  input  logic                   HREADY,
  input  logic [NUM_MASTERS-1:0] HSPLIT,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [3:0]             HMASTER,
  output logic [3:0]             HMASTERD,
  output logic                   HMASTERLOCK
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam logic [IW-1:0] DEF_IDX = IW'(DEFAULT_MASTER);
  localparam logic [IW:0] NM = (IW+1)'(NUM_MASTERS);
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [1:0] T_IDLE = 2'd0, T_NONSEQ = 2'd2, T_SEQ = 2'd3;
  localparam logic [1:0] RESP_RETRY = 2'd2, RESP_SPLIT = 2'd3;

  logic [NUM_MASTERS-1:0] grant, grant_nxt, mask, mask_nxt, elig;
  logic [IW-1:0]          grant_idx, grant_idx_nxt, master_idx, masterd_idx, rr_ptr, sel_idx;
  logic [IW:0]            rr_try;
  logic [5:0]             count, count_nxt;
  logic                   master_lock, sel_found, ptr_upd;
  logic                   locked, split_second, free_point, handover, lock_split;

  // Remaining beats after the NONSEQ beat; wrapping and incrementing bursts are alike.
  function automatic logic [5:0] burst_load(input logic [2:0] burst);
    case (burst)
      3'd0:       burst_load = 6'd0;
      3'd1:       burst_load = 6'(INCR_MAX - 1);
      3'd2, 3'd3: burst_load = 6'd3;
      3'd4, 3'd5: burst_load = 6'd7;
      default:    burst_load = 6'd15;
    endcase
  endfunction

  function automatic logic [5:0] sat_dec(input logic [5:0] v);
    sat_dec = (v == 6'd0) ? 6'd0 : v - 6'd1;
  endfunction

  assign locked       = HLOCK[grant_idx];
  assign split_second = (HRESP == RESP_SPLIT) && HREADY;
  assign free_point   = (HTRANS == T_IDLE)
                     || (HTRANS == T_NONSEQ && HBURST == 3'd0 && HREADY)
                     || (HTRANS == T_SEQ && HREADY && count == 6'd1)
                     || ((HRESP == RESP_RETRY || HRESP == RESP_SPLIT) && HREADY);
  // A locked owner only gives up the bus by dropping its request or being split.
  assign handover     = !HBUSREQ[grant_idx] || split_second || (!locked && free_point);
  assign lock_split   = locked && split_second;

  always_comb begin
    elig      = HBUSREQ & mask;
    elig[0]   = 1'b0;
    sel_idx   = '0;
    sel_found = 1'b0;
    rr_try    = '0;
    if (RR_MODE != 0) begin
      for (int k = 1; k <= NUM_MASTERS; k++) begin
        rr_try = {1'b0, rr_ptr} + (IW+1)'(k);
        if (rr_try >= NM) rr_try = rr_try - NM;
        if (!sel_found && rr_try != '0 && elig[rr_try[IW-1:0]]) begin
          sel_found = 1'b1;
          sel_idx   = rr_try[IW-1:0];
        end
      end
    end else begin
      for (int i = 1; i < NUM_MASTERS; i++) begin
        if (elig[i]) begin
          sel_found = 1'b1;
          sel_idx   = IW'(i);
        end
      end
    end
  end

  always_comb begin
    grant_idx_nxt = '0;
    ptr_upd       = 1'b0;
    if (lock_split) begin
      grant_idx_nxt = '0;
    end else if (sel_found) begin
      grant_idx_nxt = sel_idx;
      ptr_upd       = 1'b1;
    end else if (mask[DEF_IDX]) begin
      grant_idx_nxt = DEF_IDX;
    end
    grant_nxt = '0;
    grant_nxt[grant_idx_nxt] = 1'b1;
  end

  // A resume pulse overrides a split arriving for the same master.
  always_comb begin
    mask_nxt = mask;
    if (HRESP == RESP_SPLIT && !HREADY) mask_nxt[masterd_idx] = 1'b0;
    mask_nxt = mask_nxt | HSPLIT;
  end

  always_comb begin
    count_nxt = count;
    if (HTRANS == T_IDLE) begin
      count_nxt = '0;
    end else if (HREADY) begin
      if (HTRANS == T_NONSEQ)   count_nxt = burst_load(HBURST);
      else if (HTRANS == T_SEQ) count_nxt = sat_dec(count);
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      grant       <= DEF_GRANT;
      grant_idx   <= DEF_IDX;
      master_idx  <= DEF_IDX;
      masterd_idx <= DEF_IDX;
      master_lock <= 1'b0;
      mask        <= '1;
      count       <= '0;
      rr_ptr      <= DEF_IDX;
    end else begin
      mask  <= mask_nxt;
      count <= count_nxt;
      if (HREADY) begin
        master_idx  <= grant_idx;
        masterd_idx <= master_idx;
        master_lock <= HLOCK[grant_idx];
        if (handover) begin
          grant     <= grant_nxt;
          grant_idx <= grant_idx_nxt;
          if (ptr_upd) rr_ptr <= grant_idx_nxt;
        end
      end
    end
  end

  assign HGRANT      = grant;
  assign HMASTER     = 4'(master_idx);
  assign HMASTERD    = 4'(masterd_idx);
  assign HMASTERLOCK = master_lock;

endmodule

// File: doc/ahb_rr_arbiter.md
AHB_RR_ARBITER -- requirements
Module: ahb_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, meaning the number of bus masters (legal 2..16); master 0 is the dummy master.
REQ-002 SHALL have parameter DEFAULT_MASTER, default 1, meaning the master granted when no eligible request exists (legal 1..NUM_MASTERS-1).
REQ-003 SHALL have parameter RR_MODE, default 1, meaning 1 = round-robin and 0 = fixed priority (highest index wins).
REQ-004 SHALL have parameter INCR_MAX, default 16, meaning the beat limit (legal 2..64) after which an unlocked undefined-length INCR burst is re-arbitrated.
REQ-005 SHALL have the following ports, as name / direction / width / meaning:
- HCLK / in / 1 / single clock; all logic on its rising edge.
- HRESET / in / 1 / reset, synchronous and active-high.
- HBUSREQ / in / NUM_MASTERS / per-master bus request.
- HLOCK / in / NUM_MASTERS / per-master locked-transfer request.
- HTRANS / in / 2 / current transfer type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HBURST / in / 3 / burst type: SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7.
- HRESP / in / 2 / slave response: OKAY=0, ERROR=1, RETRY=2, SPLIT=3.
- HREADY / in / 1 / transfer-complete strobe.
- HSPLIT / in / NUM_MASTERS / OR of slave split-resume vectors.
- HGRANT / out / NUM_MASTERS / one-hot grant, registered.
- HMASTER / out / 4 / address-phase owner index.
- HMASTERD / out / 4 / data-phase owner index.
- HMASTERLOCK / out / 1 / current address phase is locked.

Function
REQ-006 HGRANT SHALL be exactly one-hot at all times after reset.
REQ-007 An eligible request SHALL be HBUSREQ[i] & mask[i] with i != 0; the mask resets to all ones.
REQ-008 On HRESP==SPLIT with HREADY low (first response cycle), mask[HMASTERD] SHALL clear on the next edge.
REQ-009 An HSPLIT[i] pulse SHALL set mask[i] on the next edge; if HSPLIT[i] and a new SPLIT for master i occur in the same cycle, the set wins.
REQ-010 The beat counter SHALL load on NONSEQ with HREADY: INCR4/WRAP4=3, INCR8/WRAP8=7, INCR16/WRAP16=15, SINGLE=0, INCR=INCR_MAX-1.
- It SHALL decrement on SEQ with HREADY, hold on BUSY or HREADY low, and clear on IDLE.
REQ-011 A handover point SHALL be any of:
- the granted master has HBUSREQ low;
- HTRANS==IDLE;
- NONSEQ SINGLE with HREADY;
- SEQ with HREADY and counter==1;
- second cycle of a RETRY or SPLIT response (HREADY high).
REQ-012 Locked ownership (HLOCK of the granted master high) SHALL suppress every handover point except the granted master's own HBUSREQ falling and SPLIT.
REQ-013 At a handover point, the next grant SHALL be selected as follows:
- RR_MODE=1: the first eligible index searched cyclically from the last granted index +1, skipping 0.
- RR_MODE=0: the highest eligible index.
- No eligible request: DEFAULT_MASTER if mask[DEFAULT_MASTER] is set, else master 0.
REQ-014 SPLIT while locked, or all non-dummy masks cleared, SHALL force grant to master 0 at the next handover.
REQ-015 The round-robin pointer SHALL update only when a non-dummy, non-default-fallback grant is issued.
REQ-016 HGRANT SHALL change only on an edge where HREADY is high; otherwise it holds.
REQ-017 HMASTER SHALL load the index of the granted master on each edge with HREADY high, i.e. one cycle after HGRANT.
REQ-018 HMASTERD SHALL load HMASTER on each edge with HREADY high.
REQ-019 HMASTERLOCK SHALL load HLOCK[granted index] together with HMASTER.
REQ-020 The counter SHALL saturate at 0, never underflow, and behave the same for wrapping and incrementing bursts.

Reset
REQ-021 While HRESET is high at an edge, the block SHALL set:
- HGRANT = one-hot DEFAULT_MASTER; HMASTER = HMASTERD = DEFAULT_MASTER; HMASTERLOCK = 0;
- mask = all ones; counter = 0; round-robin pointer = DEFAULT_MASTER.
REQ-022 Reset asserted mid-burst SHALL abandon the burst with no residual mask or counter state; the first post-reset cycle SHALL behave as REQ-021.

Verification
REQ-023 With NUM_MASTERS=4 and RR_MODE=1: HBUSREQ=4'b1110 held, single transfers with HREADY=1 -> grants rotate 1,2,3,1,2,3.
REQ-024 Master 2 issues INCR4 NONSEQ while master 3 requests -> HGRANT moves to 3 only on the edge after the third SEQ beat, and HMASTERD follows HMASTER one HREADY later.
REQ-025 Master 2 locked (HLOCK[2]=1) with INCR and master 3 requesting -> grant stays 2 beyond INCR_MAX beats, and HMASTERLOCK=1 throughout.
REQ-026 Master 3 receives SPLIT (two cycles) -> mask[3]=0 and grant moves to 2 or the default; a later HSPLIT[3] pulse -> master 3 is granted again at the next handover.
REQ-027 All masters split, no HSPLIT -> HGRANT=4'b0001; an HREADY=0 stall during a handover -> HGRANT unchanged until HREADY=1.
REQ-028 HRESET pulsed during a WRAP8 burst -> the next cycle shows HGRANT=4'b0010, HMASTER=1, HMASTERLOCK=0, and counter 0.
